contador_rampa_dupla: RTL and testbench

- BCD time-base counter and result register for the dual-slope ADC, directly downstream of the switch-control FSM.
- Counts clock cycles while the FSM enables it and pulses `en_3` at the end of the fixed integration interval.
- Keeps counting during de-integration and captures the count as the conversion result when `Vint_z` rises.
- Supplies the conversion result and status to the display/readout logic.

---
 rtl/adc_pkg.sv | 36 +++
 rtl/contador_rampa_dupla_if.sv | 40 ++++
 rtl/bcd_digit.sv | 36 +++
 rtl/contador_rampa_dupla.sv | 129 ++++++++++++
 tb/tb_contador_rampa_dupla.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared types and helpers for the dual-slope ADC counter slice.
//   bcd_t       - one BCD decade
//   phase_e     - counter phase, INTEG (0) / DEINT (1)
//   BCD_MAX     - largest legal decade value
//   bcd_to_seg7 - active-low gfedcba decoder, used when CONTADOR_SEG7_EN is defined
package adc_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    PHASE_INTEG = 1'b0,
    PHASE_DEINT = 1'b1
  } phase_e;

  localparam bcd_t BCD_MAX = 4'd9;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; any non-BCD code blanks.
  function automatic logic [6:0] bcd_to_seg7(input bcd_t d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/contador_rampa_dupla_if.sv
// contador_rampa_dupla_if: signal bundle between the switch-control FSM side
// (master) and the time-base counter (slave).
//   en_0, clr, Vint_z         : FSM/comparator -> counter
//   en_3, count_bcd, result_bcd,
//   result_valid, overflow,
//   phase                     : counter -> FSM/readout
//   seg7                      : counter -> display, only with CONTADOR_SEG7_EN
interface contador_rampa_dupla_if #(
  parameter int NUM_DIGITS = 3
);
  logic                      en_0;
  logic                      clr;
  logic                      Vint_z;
  logic                      en_3;
  logic [4*NUM_DIGITS-1:0]   count_bcd;
  logic [4*NUM_DIGITS-1:0]   result_bcd;
  logic                      result_valid;
  logic                      overflow;
  logic                      phase;
`ifdef CONTADOR_SEG7_EN
  logic [7*NUM_DIGITS-1:0]   seg7;
`endif

  modport master (
    output en_0, clr, Vint_z,
    input  en_3, count_bcd, result_bcd, result_valid, overflow, phase
`ifdef CONTADOR_SEG7_EN
    , input seg7
`endif
  );

  modport slave (
    input  en_0, clr, Vint_z,
    output en_3, count_bcd, result_bcd, result_valid, overflow, phase
`ifdef CONTADOR_SEG7_EN
    , output seg7
`endif
  );

endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one decade of the BCD counter.
//   clk, reset (sync, active-low), clr (sync clear)
//   inc_in    : increment this decade
//   q         : current decade value 0..9
//   carry_out : inc_in while at 9, i.e. this decade wraps this cycle
module bcd_digit
  import adc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc_in,
  output bcd_t q,
  output logic carry_out
);

  bcd_t q_q, q_d;

  assign carry_out = inc_in && (q_q == BCD_MAX);
  assign q         = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc_in) begin
      q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/contador_rampa_dupla.sv
// contador_rampa_dupla: BCD time base and result register of the dual-slope ADC.
// Counts while en_0 is high; the first full-scale wrap ends integration
// (en_3 pulse, phase -> DEINT); a Vint_z rising edge in DEINT captures the
// count into result_bcd (result_valid pulse) and freezes the counter.
//   clk, reset        : clock, synchronous active-low reset
//   bus (slave)       : en_0, clr, Vint_z in; en_3, count_bcd, result_bcd,
//                       result_valid, overflow, phase out
// Optional: define CONTADOR_SEG7_EN to add bus.seg7, active-low 7-segment
// view of result_bcd registered one cycle later.
module contador_rampa_dupla
  import adc_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter bit SAT_ON_OVF = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  contador_rampa_dupla_if.slave  bus
);

  logic [NUM_DIGITS:0]       inc;     // inc[i] increments decade i; inc[NUM_DIGITS] = full-scale wrap
  logic [4*NUM_DIGITS-1:0]   count;
  logic                      capture;
  logic                      wrap;

  phase_e                    phase_q, phase_d;
  logic                      en3_q, en3_d;
  logic                      rv_q, rv_d;
  logic                      ovf_q, ovf_d;
  logic                      pend_q, pend_d;
  logic                      done_q, done_d;
  logic                      vzp_q, vzp_d;
  logic [4*NUM_DIGITS-1:0]   result_q, result_d;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (bus.clr),
      .inc_in    (inc[g]),
      .q         (count[4*g +: 4]),
      .carry_out (inc[g+1])
    );
  end

  // Capture outranks counting, so the decades see no increment on the
  // capture cycle and result_bcd gets the pre-increment value.
  assign capture = (phase_q == PHASE_DEINT) && !done_q && bus.en_0 && bus.Vint_z && !vzp_q;
  assign inc[0]  = bus.en_0 && !done_q && !capture && !bus.clr;
  assign wrap    = inc[NUM_DIGITS];

  always_comb begin
    phase_d  = phase_q;
    en3_d    = 1'b0;
    rv_d     = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    pend_d   = pend_q;
    done_d   = done_q;
    // Edge register keeps sampling through clr so a Vint_z already high is
    // never mistaken for a fresh edge once DEINT starts.
    vzp_d    = bus.en_0 ? bus.Vint_z : vzp_q;

    if (bus.clr) begin
      phase_d = PHASE_INTEG;
      pend_d  = 1'b0;
      done_d  = 1'b0;
    end else if (capture) begin
      result_d = (SAT_ON_OVF && pend_q) ? {NUM_DIGITS{BCD_MAX}} : count;
      ovf_d    = pend_q;
      pend_d   = 1'b0;
      rv_d     = 1'b1;
      done_d   = 1'b1;
    end else if (wrap) begin
      if (phase_q == PHASE_INTEG) begin
        phase_d = PHASE_DEINT;
        en3_d   = 1'b1;
      end else begin
        pend_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q  <= PHASE_INTEG;
      en3_q    <= 1'b0;
      rv_q     <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      vzp_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      en3_q    <= en3_d;
      rv_q     <= rv_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      vzp_q    <= vzp_d;
    end
  end

  assign bus.en_3         = en3_q;
  assign bus.count_bcd    = count;
  assign bus.result_bcd   = result_q;
  assign bus.result_valid = rv_q;
  assign bus.overflow     = ovf_q;
  assign bus.phase        = phase_q;

`ifdef CONTADOR_SEG7_EN
  logic [7*NUM_DIGITS-1:0] seg7_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      seg7_q <= '1;
    end else begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        seg7_q[7*i +: 7] <= bcd_to_seg7(result_q[4*i +: 4]);
      end
    end
  end

  assign bus.seg7 = seg7_q;
`endif

endmodule

// File: tb/tb_contador_rampa_dupla.sv
// Bench for contador_rampa_dupla (NUM_DIGITS=3, SAT_ON_OVF=1): integer-level
// reference model checked every cycle, plus directed literal checks.
module tb_contador_rampa_dupla;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  contador_rampa_dupla_if #(.NUM_DIGITS(3)) bus ();

  contador_rampa_dupla #(.NUM_DIGITS(3), .SAT_ON_OVF(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int en3_pulses = 0;

  // Reference model: plain integer count 0..999 and conversion flags.
  int m_cnt = 0;
  int m_res = 0;
  bit m_phase = 0, m_en3 = 0, m_rv = 0, m_ovf = 0, m_pend = 0, m_done = 0, m_prev = 0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_en3 = 0;
    m_rv  = 0;
    if (!reset) begin
      m_cnt = 0; m_res = 0; m_phase = 0; m_ovf = 0; m_pend = 0; m_done = 0; m_prev = 0;
    end else if (bus.clr) begin
      m_cnt = 0; m_phase = 0; m_pend = 0; m_done = 0;
      if (bus.en_0) m_prev = bus.Vint_z;
    end else if (bus.en_0) begin
      if (m_phase && !m_done && bus.Vint_z && !m_prev) begin
        m_res  = m_pend ? 999 : m_cnt;
        m_ovf  = m_pend;
        m_pend = 0;
        m_rv   = 1;
        m_done = 1;
      end else if (!m_done) begin
        m_cnt = (m_cnt + 1) % 1000;
        if (m_cnt == 0) begin
          if (!m_phase) begin m_phase = 1; m_en3 = 1; end
          else m_pend = 1;
        end
      end
      m_prev = bus.Vint_z;
    end
  end

  always @(negedge clk) begin
    if (bus.en_3 === 1'b1) en3_pulses++;
    check("count_bcd", 32'(bus.count_bcd), 32'(to_bcd(m_cnt)));
    check("phase", 32'(bus.phase), 32'(m_phase));
    check("en_3", 32'(bus.en_3), 32'(m_en3));
    check("result_valid", 32'(bus.result_valid), 32'(m_rv));
    check("result_bcd", 32'(bus.result_bcd), 32'(to_bcd(m_res)));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
  end

  task automatic cyc(input logic e, input logic v, input logic c);
    bus.en_0 = e; bus.Vint_z = v; bus.clr = c;
    @(negedge clk);
  endtask

  initial begin
    bit vz = 0;
    bit e, c;
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    check("lit_reset_count", 32'(bus.count_bcd), 32'h0);
    check("lit_reset_result", 32'(bus.result_bcd), 32'h0);
    reset = 1'b1;

    // Integration: 1000 counts to the first wrap.
    repeat (999) cyc(1, 0, 0);
    check("lit_pre_wrap_count", 32'(bus.count_bcd), 32'h999);
    check("lit_pre_wrap_phase", 32'(bus.phase), 32'h0);
    cyc(1, 0, 0);
    check("lit_wrap_count", 32'(bus.count_bcd), 32'h000);
    check("lit_wrap_phase", 32'(bus.phase), 32'h1);
    check("lit_wrap_en3", 32'(bus.en_3), 32'h1);
    cyc(1, 0, 0);
    check("lit_en3_single", 32'(en3_pulses), 32'd1);

    // Normal conversion at 347.
    repeat (346) cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("lit_res_347", 32'(bus.result_bcd), 32'h347);
    check("lit_rv_347", 32'(bus.result_valid), 32'h1);
    check("lit_ovf_347", 32'(bus.overflow), 32'h0);
    cyc(1, 1, 0);
    check("lit_frozen", 32'(bus.count_bcd), 32'h347);
    check("lit_rv_drop", 32'(bus.result_valid), 32'h0);
    cyc(1, 0, 1);
    check("lit_clr_result_kept", 32'(bus.result_bcd), 32'h347);

    // Over-range de-integration, then a normal one clears overflow.
    repeat (1000) cyc(1, 0, 0);
    repeat (1005) cyc(1, 0, 0);
    check("lit_ovf_count", 32'(bus.count_bcd), 32'h005);
    cyc(1, 1, 0);
    check("lit_sat_result", 32'(bus.result_bcd), 32'h999);
    check("lit_ovf_set", 32'(bus.overflow), 32'h1);
    cyc(1, 0, 1);
    repeat (1020) cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("lit_res_020", 32'(bus.result_bcd), 32'h020);
    check("lit_ovf_clear", 32'(bus.overflow), 32'h0);

    // Vint_z pulse during integration is ignored.
    cyc(1, 0, 1);
    repeat (500) cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    check("lit_integ_no_rv", 32'(bus.result_valid), 32'h0);
    check("lit_integ_result", 32'(bus.result_bcd), 32'h020);
    repeat (497) cyc(1, 0, 0);
    check("lit_integ_999", 32'(bus.count_bcd), 32'h999);
    cyc(1, 0, 0);
    check("lit_integ_en3", 32'(bus.en_3), 32'h1);

    // clr mid-DEINT at 120.
    repeat (120) cyc(1, 0, 0);
    check("lit_deint_120", 32'(bus.count_bcd), 32'h120);
    cyc(1, 0, 1);
    check("lit_clr_count", 32'(bus.count_bcd), 32'h000);
    check("lit_clr_phase", 32'(bus.phase), 32'h0);
    check("lit_clr_result", 32'(bus.result_bcd), 32'h020);

    // Reset mid-integration.
    repeat (200) cyc(1, 0, 0);
    reset = 1'b0;
    cyc(1, 0, 0);
    check("lit_rst_count", 32'(bus.count_bcd), 32'h0);
    check("lit_rst_result", 32'(bus.result_bcd), 32'h0);
    reset = 1'b1;

    // en_0 pause at 050.
    repeat (50) cyc(1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, (i == 4), 0);
    check("lit_hold_050", 32'(bus.count_bcd), 32'h050);
    cyc(1, 0, 0);
    check("lit_resume_051", 32'(bus.count_bcd), 32'h051);

    // Randomised operation against the model.
    for (int i = 0; i < 4000; i++) begin
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) vz = ~vz;
      c = ($urandom_range(0, 2499) == 0);
      reset = ($urandom_range(0, 3999) != 0);
      cyc(e, vz, c);
    end
    reset = 1'b1;
    cyc(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
